dmem_demux: RTL and testbench

- Routes the single data-memory request stream from the LSU to one of three address-mapped targets: RAM, MMIO and boot ROM.
- Returns each target's responses to the LSU in order.
- Unmapped addresses go to an internal error responder.
- Sits between the LSU and the data-side slaves. It is the fan-out counterpart of the result-select muxes in the datapath.

---
 rtl/dmem_demux_if.sv | 50 +++++
 rtl/dmem_demux.sv | 169 ++++++++++++++++
 tb/tb_dmem_demux.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_demux_if.sv
// ============================================================================
// Module      : dmem_demux_if
// Description : Data-memory request/response bundle between the LSU, the
//               dmem_demux fan-out and the three data-side slaves.
//               The slave modport is the demux view, the master modport is
//               the surrounding LSU + slaves view.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dmem_demux_if #(
  parameter int WIDTH = 32
);
  // LSU side
  logic                   m_req_valid;
  logic                   m_req_ready;
  logic [WIDTH-1:0]       m_addr;
  logic [WIDTH-1:0]       m_wdata;
  logic                   m_we;
  logic [WIDTH/8-1:0]     m_be;
  logic                   m_rsp_valid;
  logic [WIDTH-1:0]       m_rdata;
  logic                   m_rsp_err;

  // Slave side (three targets)
  logic [2:0]             s_req_valid;
  logic [2:0]             s_req_ready;
  logic [WIDTH-1:0]       s_addr;
  logic [WIDTH-1:0]       s_wdata;
  logic                   s_we;
  logic [WIDTH/8-1:0]     s_be;
  logic [2:0]             s_rsp_valid;
  logic [3*WIDTH-1:0]     s_rdata;

  modport slave (
    input  m_req_valid, m_addr, m_wdata, m_we, m_be,
    output m_req_ready, m_rsp_valid, m_rdata, m_rsp_err,
    output s_req_valid, s_addr, s_wdata, s_we, s_be,
    input  s_req_ready, s_rsp_valid, s_rdata
  );

  modport master (
    output m_req_valid, m_addr, m_wdata, m_we, m_be,
    input  m_req_ready, m_rsp_valid, m_rdata, m_rsp_err,
    input  s_req_valid, s_addr, s_wdata, s_we, s_be,
    output s_req_ready, s_rsp_valid, s_rdata
  );
endinterface

`default_nettype wire

// File: rtl/dmem_demux.sv
// ============================================================================
// Module      : dmem_demux
// Description : Address-decoded fan-out of the LSU data-memory request stream
//               to RAM / MMIO / boot ROM plus an internal error responder.
//               Responses are returned in order by stalling any request to a
//               target other than the one that owns outstanding requests.
//               Optional statistics counters are enabled by defining
//               DMEM_DEMUX_STATS_EN (adds err_count and drop_count ports).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_demux #(
  parameter int               WIDTH     = 32,
  parameter int               MAX_OUTST = 4,
  parameter logic [WIDTH-1:0] S0_BASE   = 32'h0000_0000,
  parameter logic [WIDTH-1:0] S0_MASK   = 32'hFFFF_0000,
  parameter logic [WIDTH-1:0] S1_BASE   = 32'h1000_0000,
  parameter logic [WIDTH-1:0] S1_MASK   = 32'hFFFF_F000,
  parameter logic [WIDTH-1:0] S2_BASE   = 32'h2000_0000,
  parameter logic [WIDTH-1:0] S2_MASK   = 32'hFFFF_C000
) (
  input  logic        clk,
  input  logic        reset,
  dmem_demux_if.slave bus
`ifdef DMEM_DEMUX_STATS_EN
  ,
  output logic [15:0] err_count,
  output logic [15:0] drop_count
`endif
);

  localparam int CW = $clog2(MAX_OUTST + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_OUTST);
  localparam logic [CW-1:0] CNT_ZERO = '0;

  // Target encoding (also the owner state held while requests are in flight)
  localparam logic [1:0] TGT_RAM  = 2'd0;
  localparam logic [1:0] TGT_MMIO = 2'd1;
  localparam logic [1:0] TGT_ROM  = 2'd2;
  localparam logic [1:0] TGT_ERR  = 2'd3;

  logic [CW-1:0] r_cnt;
  logic [1:0]    r_cur;

  logic [1:0]    w_tgt;
  logic          w_busy;
  logic          w_not_full;
  logic          w_same_tgt;
  logic          w_tgt_ready;
  logic          w_allow;
  logic          w_acc;
  logic          w_rsp;

  // Broadcast request fields to every slave
  assign bus.s_addr  = bus.m_addr;
  assign bus.s_wdata = bus.m_wdata;
  assign bus.s_we    = bus.m_we;
  assign bus.s_be    = bus.m_be;

  // Address decode with fixed priority S0 > S1 > S2, fall-through to ERR
  always_comb begin
    w_tgt = TGT_ERR;
    if ((bus.m_addr & S2_MASK) == S2_BASE) w_tgt = TGT_ROM;
    if ((bus.m_addr & S1_MASK) == S1_BASE) w_tgt = TGT_MMIO;
    if ((bus.m_addr & S0_MASK) == S0_BASE) w_tgt = TGT_RAM;
  end

  assign w_busy     = (r_cnt != CNT_ZERO);
  // r_cnt never exceeds CNT_MAX, so "not equal" is the same as "less than"
  assign w_not_full = (r_cnt != CNT_MAX);
  assign w_same_tgt = !w_busy || (w_tgt == r_cur);
  assign w_allow    = bus.m_req_valid && w_not_full && w_same_tgt;

  // Ready of the decoded target; the error responder always accepts
  always_comb begin
    w_tgt_ready = 1'b1;
    case (w_tgt)
      TGT_RAM:  w_tgt_ready = bus.s_req_ready[0];
      TGT_MMIO: w_tgt_ready = bus.s_req_ready[1];
      TGT_ROM:  w_tgt_ready = bus.s_req_ready[2];
      default:  w_tgt_ready = 1'b1;
    endcase
  end

  assign bus.m_req_ready = w_not_full && w_same_tgt && w_tgt_ready;
  assign w_acc           = bus.m_req_valid && bus.m_req_ready;

  // Per-slave request valid; deliberately independent of s_req_ready
  always_comb begin
    bus.s_req_valid = 3'b000;
    case (w_tgt)
      TGT_RAM:  bus.s_req_valid[0] = w_allow;
      TGT_MMIO: bus.s_req_valid[1] = w_allow;
      TGT_ROM:  bus.s_req_valid[2] = w_allow;
      default:  bus.s_req_valid    = 3'b000;
    endcase
  end

  // Response pass-through from the owning target, or the error responder
  always_comb begin
    bus.m_rsp_valid = 1'b0;
    bus.m_rdata     = '0;
    bus.m_rsp_err   = 1'b0;
    if (w_busy) begin
      case (r_cur)
        TGT_RAM: begin
          bus.m_rsp_valid = bus.s_rsp_valid[0];
          bus.m_rdata     = bus.s_rdata[WIDTH-1:0];
        end
        TGT_MMIO: begin
          bus.m_rsp_valid = bus.s_rsp_valid[1];
          bus.m_rdata     = bus.s_rdata[2*WIDTH-1:WIDTH];
        end
        TGT_ROM: begin
          bus.m_rsp_valid = bus.s_rsp_valid[2];
          bus.m_rdata     = bus.s_rdata[3*WIDTH-1:2*WIDTH];
        end
        default: begin
          bus.m_rsp_valid = 1'b1;
          bus.m_rsp_err   = 1'b1;
        end
      endcase
    end
  end

  assign w_rsp = bus.m_rsp_valid;

  // Outstanding counter and owner; simultaneous accept+response cancel out
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
      r_cur <= TGT_RAM;
    end else begin
      if (w_acc) r_cur <= w_tgt;
      r_cnt <= r_cnt + {{(CW-1){1'b0}}, w_acc} - {{(CW-1){1'b0}}, w_rsp};
    end
  end

`ifdef DMEM_DEMUX_STATS_EN
  logic [2:0]  w_drop;
  logic [1:0]  w_drop_n;
  logic [16:0] w_drop_sum;
  logic        w_err_inc;

  // A slave response is dropped unless it comes from the current owner while busy
  for (genvar i = 0; i < 3; i++) begin : g_drop
    assign w_drop[i] = bus.s_rsp_valid[i] && !(w_busy && (r_cur == 2'(i)));
  end

  assign w_drop_n   = {1'b0, w_drop[0]} + {1'b0, w_drop[1]} + {1'b0, w_drop[2]};
  assign w_drop_sum = {1'b0, drop_count} + {15'd0, w_drop_n};
  assign w_err_inc  = w_acc && (w_tgt == TGT_ERR);

  // Saturating statistics counters
  always_ff @(posedge clk) begin
    if (reset) begin
      err_count  <= 16'd0;
      drop_count <= 16'd0;
    end else begin
      if (w_err_inc && (err_count != 16'hFFFF)) err_count <= err_count + 16'd1;
      drop_count <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_dmem_demux.sv
// ============================================================================
// Module      : tb_dmem_demux
// Description : Directed self-checking bench for dmem_demux. Optional counter
//               checks are compiled in when DMEM_DEMUX_STATS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_demux;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_cnt2 [9] = '{1, 2, 3, 4, 3, 3, 2, 1, 0};

  always #5 clk = ~clk;

  dmem_demux_if #(.WIDTH(32)) bus ();
  dmem_demux_if #(.WIDTH(32)) ovl ();

`ifdef DMEM_DEMUX_STATS_EN
  logic [15:0] err_count, drop_count, ovl_err_count, ovl_drop_count;
`endif

  dmem_demux #(.WIDTH(32), .MAX_OUTST(4)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef DMEM_DEMUX_STATS_EN
    ,
    .err_count  (err_count),
    .drop_count (drop_count)
`endif
  );

  // Second instance with S2 overlapping S0 at base 0
  dmem_demux #(.WIDTH(32), .MAX_OUTST(4), .S2_BASE(32'h0000_0000), .S2_MASK(32'hFFFF_C000)) u_ovl (
    .clk   (clk),
    .reset (reset),
    .bus   (ovl)
`ifdef DMEM_DEMUX_STATS_EN
    ,
    .err_count  (ovl_err_count),
    .drop_count (ovl_drop_count)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset           = 1'b1;
    bus.m_req_valid = 1'b0;
    bus.m_addr      = '0;
    bus.m_wdata     = '0;
    bus.m_we        = 1'b0;
    bus.m_be        = 4'hF;
    bus.s_req_ready = 3'b000;
    bus.s_rsp_valid = 3'b000;
    bus.s_rdata     = '0;
    ovl.m_req_valid = 1'b0;
    ovl.m_addr      = '0;
    ovl.m_wdata     = '0;
    ovl.m_we        = 1'b0;
    ovl.m_be        = 4'hF;
    ovl.s_req_ready = 3'b000;
    ovl.s_rsp_valid = 3'b000;
    ovl.s_rdata     = '0;
    tick();
    tick();
    reset = 1'b0;

    // ---------------- reset state ----------------
    bus.m_addr      = 32'h0000_0100;
    bus.s_req_ready = 3'b111;
    settle();
    chk("rst_cnt",   32'(u_dut.r_cnt), 0);
    chk("rst_rspv",  32'(bus.m_rsp_valid), 0);
    chk("rst_rdata", bus.m_rdata, 0);
    chk("rst_err",   32'(bus.m_rsp_err), 0);
    chk("rst_ready", 32'(bus.m_req_ready), 1);
    chk("rst_sval",  32'(bus.s_req_valid), 0);
`ifdef DMEM_DEMUX_STATS_EN
    chk("rst_errcnt",  32'(err_count), 0);
    chk("rst_dropcnt", 32'(drop_count), 0);
`endif

    // ---------------- idle decode ----------------
    bus.m_req_valid = 1'b1;
    bus.m_addr = 32'h2000_0010; settle();
    chk("dec_rom", 32'(bus.s_req_valid), 32'b100);
    bus.m_addr = 32'h1000_0FFC; settle();
    chk("dec_mmio", 32'(bus.s_req_valid), 32'b010);
    bus.m_addr = 32'h1000_1000; settle();
    chk("dec_err_sval", 32'(bus.s_req_valid), 0);
    chk("dec_err_ready", 32'(bus.m_req_ready), 1);
    bus.m_addr = 32'h2000_4000; settle();
    chk("dec_rom_edge", 32'(bus.s_req_valid), 0);
    bus.m_req_valid = 1'b0;

    // ---------------- single RAM load ----------------
    bus.s_req_ready = 3'b001;
    bus.m_req_valid = 1'b1;
    bus.m_addr      = 32'h0000_0100;
    settle();
    chk("t1_sval",  32'(bus.s_req_valid), 32'b001);
    chk("t1_ready", 32'(bus.m_req_ready), 1);
    chk("t1_saddr", bus.s_addr, 32'h0000_0100);
    tick();
    bus.m_req_valid = 1'b0;
    settle();
    chk("t1_wait_rspv", 32'(bus.m_rsp_valid), 0);
    chk("t1_cnt1", 32'(u_dut.r_cnt), 1);
    tick();
    bus.s_rsp_valid = 3'b001;
    bus.s_rdata     = {64'h0, 32'hDEAD_BEEF};
    settle();
    chk("t1_rspv",  32'(bus.m_rsp_valid), 1);
    chk("t1_rdata", bus.m_rdata, 32'hDEAD_BEEF);
    chk("t1_err",   32'(bus.m_rsp_err), 0);
    tick();
    bus.s_rsp_valid = 3'b000;
    settle();
    chk("t1_cnt0", 32'(u_dut.r_cnt), 0);
    chk("t1_rspv_off", 32'(bus.m_rsp_valid), 0);

    // ---------------- 4 back-to-back + held 5th ----------------
    for (int c = 0; c < 9; c++) begin
      bus.m_req_valid = (c <= 5);
      bus.m_addr      = 32'h0000_0200 + 32'(4 * ((c < 4) ? c : 4));
      bus.s_rsp_valid = (c >= 4) ? 3'b001 : 3'b000;
      bus.s_rdata     = {64'h0, 32'hA000_0000 + 32'(c - 4)};
      settle();
      if (c <= 5) begin
        chk("t2_ready", 32'(bus.m_req_ready), (c == 4) ? 0 : 1);
        chk("t2_sval",  32'(bus.s_req_valid), (c == 4) ? 0 : 1);
      end
      chk("t2_rspv", 32'(bus.m_rsp_valid), (c >= 4) ? 1 : 0);
      if (c >= 4) chk("t2_rdata", bus.m_rdata, 32'hA000_0000 + 32'(c - 4));
      tick();
      chk("t2_cnt", 32'(u_dut.r_cnt), 32'(exp_cnt2[c]));
    end
    bus.m_req_valid = 1'b0;
    bus.s_rsp_valid = 3'b000;

    // ---------------- target switch stall ----------------
    bus.s_req_ready = 3'b011;
    bus.m_req_valid = 1'b1;
    bus.m_addr      = 32'h0000_0300;
    tick();
    bus.m_addr      = 32'h0000_0304;
    tick();
    bus.m_addr      = 32'h1000_0004;
    bus.m_we        = 1'b1;
    bus.m_wdata     = 32'hCAFE_0001;
    settle();
    chk("t3_c2_ready", 32'(bus.m_req_ready), 0);
    chk("t3_c2_sval",  32'(bus.s_req_valid), 0);
    tick();
    bus.s_rsp_valid = 3'b001;
    bus.s_rdata     = {64'h0, 32'h0000_1111};
    settle();
    chk("t3_c3_ready", 32'(bus.m_req_ready), 0);
    chk("t3_c3_sval",  32'(bus.s_req_valid), 0);
    chk("t3_c3_rdata", bus.m_rdata, 32'h0000_1111);
    tick();
    bus.s_rdata     = {64'h0, 32'h0000_2222};
    settle();
    chk("t3_c4_ready", 32'(bus.m_req_ready), 0);
    chk("t3_c4_sval",  32'(bus.s_req_valid), 0);
    chk("t3_c4_rspv",  32'(bus.m_rsp_valid), 1);
    chk("t3_c4_rdata", bus.m_rdata, 32'h0000_2222);
    tick();
    bus.s_rsp_valid = 3'b000;
    settle();
    chk("t3_c5_sval",  32'(bus.s_req_valid), 32'b010);
    chk("t3_c5_ready", 32'(bus.m_req_ready), 1);
    chk("t3_c5_we",    32'(bus.s_we), 1);
    chk("t3_c5_wdata", bus.s_wdata, 32'hCAFE_0001);
    tick();
    bus.m_req_valid = 1'b0;
    bus.m_we        = 1'b0;
    bus.s_rsp_valid = 3'b011;
    bus.s_rdata     = {32'h0, 32'h0000_0055, 32'hBAD0_BAD0};
    settle();
    chk("t3_c6_rspv",  32'(bus.m_rsp_valid), 1);
    chk("t3_c6_rdata", bus.m_rdata, 32'h0000_0055);
    chk("t3_c6_err",   32'(bus.m_rsp_err), 0);
    tick();
    bus.s_rsp_valid = 3'b000;
    settle();
    chk("t3_cnt0", 32'(u_dut.r_cnt), 0);
`ifdef DMEM_DEMUX_STATS_EN
    chk("t3_dropcnt", 32'(drop_count), 1);
`endif

    // ---------------- unmapped access ----------------
    bus.s_req_ready = 3'b000;
    bus.m_req_valid = 1'b1;
    bus.m_addr      = 32'h3000_0000;
    settle();
    chk("t4_ready", 32'(bus.m_req_ready), 1);
    chk("t4_sval",  32'(bus.s_req_valid), 0);
    chk("t4_rspv0", 32'(bus.m_rsp_valid), 0);
    tick();
    bus.m_req_valid = 1'b0;
    settle();
    chk("t4_rspv",  32'(bus.m_rsp_valid), 1);
    chk("t4_err",   32'(bus.m_rsp_err), 1);
    chk("t4_rdata", bus.m_rdata, 0);
    tick();
    settle();
    chk("t4_cnt0",  32'(u_dut.r_cnt), 0);
    chk("t4_rspv_off", 32'(bus.m_rsp_valid), 0);
`ifdef DMEM_DEMUX_STATS_EN
    chk("t4_errcnt", 32'(err_count), 1);
`endif

    // ---------------- reset with requests in flight ----------------
    bus.s_req_ready = 3'b001;
    bus.m_req_valid = 1'b1;
    bus.m_addr      = 32'h0000_0400;
    tick();
    tick();
    tick();
    bus.m_req_valid = 1'b0;
    settle();
    chk("t5_cnt3", 32'(u_dut.r_cnt), 3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    settle();
    chk("t5_cnt0", 32'(u_dut.r_cnt), 0);
    bus.s_rsp_valid = 3'b001;
    bus.s_rdata     = {64'h0, 32'h9999_9999};
    settle();
    chk("t5_rspv",  32'(bus.m_rsp_valid), 0);
    chk("t5_rdata", bus.m_rdata, 0);
    tick();
    bus.s_rsp_valid = 3'b000;
    settle();
    chk("t5_cnt_after", 32'(u_dut.r_cnt), 0);
`ifdef DMEM_DEMUX_STATS_EN
    chk("t5_dropcnt", 32'(drop_count), 1);
    chk("t5_errcnt",  32'(err_count), 0);
`endif

    // ---------------- overlapping S0/S2 priority ----------------
    ovl.s_req_ready = 3'b111;
    ovl.m_req_valid = 1'b1;
    ovl.m_addr      = 32'h0000_0000;
    settle();
    chk("t6_prio0", 32'(ovl.s_req_valid), 32'b001);
    ovl.m_addr      = 32'h0000_1000;
    settle();
    chk("t6_prio1", 32'(ovl.s_req_valid), 32'b001);
    ovl.m_req_valid = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
